// File: rtl/mcs4_pkg.sv
// Shared MCS-4 bus types: instruction-cycle phases, I/O-RAM opcodes and
// the OPR nibbles a bus initiator emits.
package mcs4;

    localparam int unsigned ADDR_W = 8;

    typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} instr_cyc_t;

    typedef enum logic [3:0] {
        WRM = 4'h0, WMP = 4'h1, WRR = 4'h2, WPM = 4'h3,
        WR0 = 4'h4, WR1 = 4'h5, WR2 = 4'h6, WR3 = 4'h7,
        SBM = 4'h8, RDM = 4'h9, RDR = 4'hA, ADM = 4'hB,
        RD0 = 4'hC, RD1 = 4'hD, RD2 = 4'hE, RD3 = 4'hF
    } ioram_opa_t;

    typedef logic [3:0] char_t;

    typedef enum logic [1:0] {BM_IDLE, BM_SRC_CYC, BM_IO_CYC} bm_state_t;

    localparam char_t OPR_NOP    = 4'h0;
    localparam char_t OPR_SRC    = 4'h2;
    localparam char_t OPR_IO     = 4'hE;
    // SRC OPA: register pair 0 with the trailing 1 bit
    localparam char_t SRC_OPA_P0 = 4'h1;

    function automatic logic is_ioram_read(input ioram_opa_t opa);
        logic [3:0] v;
        v = opa;
        return v[3];
    endfunction

endpackage

// File: rtl/mcs4_phase_gen.sv
// Eight-phase instruction-cycle counter; sync marks X3 so the next cycle is A1.
module mcs4_phase_gen
    import mcs4::*;
(
    input  logic       clk,
    input  logic       rst,
    output instr_cyc_t phase,
    output logic       sync
);

    // sync is registered against the phase about to be entered
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= X3;
            sync  <= 1'b1;
        end else begin
            phase <= instr_cyc_t'(3'(phase + 3'd1));
            sync  <= (phase == X2);
        end
    end

endmodule

// File: rtl/ioram_bus_master.sv
// MCS-4 RAM/IO bus initiator: turns one host command into an optional SRC
// cycle followed by an I/O instruction cycle, and returns the X2 read nibble.
module ioram_bus_master
    import mcs4::*;
#(
    parameter bit SKIP_REDUNDANT_SRC = 1'b1,
    parameter bit IDLE_NOPS          = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              sync,
    output logic              cm_ram,
    input  char_t             dbus_in,
    output char_t             dbus_out,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  ioram_opa_t        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  char_t             cmd_wdata,
    output logic              rsp_valid,
    output char_t             rsp_data
);

    instr_cyc_t        phase;
    instr_cyc_t        phase_nxt;
    bm_state_t         state_q;
    bm_state_t         state_nxt;
    logic              pending_q;
    logic              pending_nxt;
    ioram_opa_t        op_q;
    logic [ADDR_W-1:0] addr_q;
    char_t             wdata_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic              last_valid_q;
    logic              take;
    logic              skip_src;
    logic              src_done;
    char_t             dbus_nxt;
    char_t             rsp_data_nxt;
    logic              cm_ram_nxt;
    logic              cmd_ready_nxt;
    logic              rsp_valid_nxt;

    mcs4_phase_gen u_phase (
        .clk   (clk),
        .rst   (rst),
        .phase (phase),
        .sync  (sync)
    );

    assign phase_nxt = instr_cyc_t'(3'(phase + 3'd1));
    assign take      = cmd_valid && cmd_ready;
    assign skip_src  = SKIP_REDUNDANT_SRC && last_valid_q && (addr_q == last_addr_q);
    assign src_done  = (state_q == BM_SRC_CYC) && (phase == X3);

    // State, command latch and last-SRC tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BM_IDLE;
            pending_q    <= 1'b0;
            op_q         <= WRM;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_addr_q  <= '0;
            last_valid_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            pending_q <= pending_nxt;
            if (take) begin
                op_q    <= cmd_op;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end
            if (src_done) begin
                last_addr_q  <= addr_q;
                last_valid_q <= 1'b1;
            end
        end
    end

    // Next state plus the bus drive for the phase being entered
    always_comb begin
        state_nxt     = state_q;
        pending_nxt   = pending_q;
        dbus_nxt      = '0;
        cm_ram_nxt    = 1'b0;
        rsp_valid_nxt = 1'b0;
        rsp_data_nxt  = rsp_data;

        if (take) begin
            pending_nxt = 1'b1;
        end

        if (phase == X3) begin
            case (state_q)
                BM_IDLE:    if (pending_q) state_nxt = skip_src ? BM_IO_CYC : BM_SRC_CYC;
                BM_SRC_CYC: state_nxt = BM_IO_CYC;
                BM_IO_CYC: begin
                    state_nxt   = BM_IDLE;
                    pending_nxt = 1'b0;
                end
                default:    state_nxt = BM_IDLE;
            endcase
        end

        if ((state_q == BM_IO_CYC) && (phase == X2)) begin
            rsp_valid_nxt = 1'b1;
            rsp_data_nxt  = is_ioram_read(op_q) ? dbus_in : 4'h0;
        end

        case (state_nxt)
            BM_SRC_CYC: begin
                case (phase_nxt)
                    M1: dbus_nxt = OPR_SRC;
                    M2: dbus_nxt = SRC_OPA_P0;
                    X2: begin
                        dbus_nxt   = addr_q[3:0];
                        cm_ram_nxt = 1'b1;
                    end
                    X3: dbus_nxt = addr_q[7:4];
                    default: ;
                endcase
            end
            BM_IO_CYC: begin
                case (phase_nxt)
                    M1: dbus_nxt = OPR_IO;
                    M2: begin
                        dbus_nxt   = char_t'(op_q);
                        cm_ram_nxt = 1'b1;
                    end
                    X2: dbus_nxt = is_ioram_read(op_q) ? 4'h0 : wdata_q;
                    default: ;
                endcase
            end
            default: begin
                if (IDLE_NOPS && (phase_nxt == M1)) dbus_nxt = OPR_NOP;
            end
        endcase

        cmd_ready_nxt = (state_nxt == BM_IDLE) && !pending_nxt;
    end

    // Registered bus and host-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cm_ram    <= 1'b0;
            dbus_out  <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            cm_ram    <= cm_ram_nxt;
            dbus_out  <= dbus_nxt;
            cmd_ready <= cmd_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
        end
    end

endmodule

// File: tb/tb_ioram_bus_master.sv
// Bench for ioram_bus_master: one instance with redundant-SRC skipping, one
// without, checked against a phase-table model of the bus protocol.
module tb_ioram_bus_master;
    import mcs4::*;

    localparam bit SKIP_A = 1'b1;
    localparam bit SKIP_B = 1'b0;

    logic       clk;
    logic       rst;
    char_t      dbus_in;
    logic       cmd_valid;
    ioram_opa_t cmd_op;
    logic [7:0] cmd_addr;
    char_t      cmd_wdata;
    bit         sel;

    logic  cmd_valid_a, cmd_valid_b;
    logic  sync_a, cm_a, ready_a, rv_a;
    logic  sync_b, cm_b, ready_b, rv_b;
    char_t dbus_a, rd_a, dbus_b, rd_b;
    logic  m_sync, m_cm, m_ready, m_rv;
    char_t m_dbus, m_rd;

    int         n_cmp;
    int         n_err;
    int         ph;
    logic [7:0] la [2];
    bit         lv [2];

    assign cmd_valid_a = cmd_valid && !sel;
    assign cmd_valid_b = cmd_valid && sel;
    assign m_sync  = sel ? sync_b  : sync_a;
    assign m_cm    = sel ? cm_b    : cm_a;
    assign m_ready = sel ? ready_b : ready_a;
    assign m_rv    = sel ? rv_b    : rv_a;
    assign m_dbus  = sel ? dbus_b  : dbus_a;
    assign m_rd    = sel ? rd_b    : rd_a;

    ioram_bus_master #(.SKIP_REDUNDANT_SRC(SKIP_A), .IDLE_NOPS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .sync(sync_a), .cm_ram(cm_a),
        .dbus_in(dbus_in), .dbus_out(dbus_a),
        .cmd_valid(cmd_valid_a), .cmd_ready(ready_a), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rv_a), .rsp_data(rd_a)
    );

    ioram_bus_master #(.SKIP_REDUNDANT_SRC(SKIP_B), .IDLE_NOPS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .sync(sync_b), .cm_ram(cm_b),
        .dbus_in(dbus_in), .dbus_out(dbus_b),
        .cmd_valid(cmd_valid_b), .cmd_ready(ready_b), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rv_b), .rsp_data(rd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no end of test, expected end before time limit");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one bus cycle and sample mid-cycle
    task automatic tick();
        @(posedge clk);
        ph = (ph + 1) % 8;
        @(negedge clk);
        chk("sync", 8'(m_sync), 8'(ph == 7));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        cmd_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("rst_sync",      8'({sync_a, sync_b}),   8'h3);
        chk("rst_cm_ram",    8'({cm_a, cm_b}),       8'h0);
        chk("rst_dbus",      8'({dbus_a, dbus_b}),   8'h0);
        chk("rst_cmd_ready", 8'({ready_a, ready_b}), 8'h0);
        chk("rst_rsp_valid", 8'({rv_a, rv_b}),       8'h0);
        chk("rst_rsp_data",  8'({rd_a, rd_b}),       8'h0);
        rst = 1'b0;
        ph = 7;
        lv[0] = 1'b0;
        lv[1] = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            chk("idle_sync_a", 8'(sync_a), 8'(ph == 7));
            chk("idle_sync_b", 8'(sync_b), 8'(ph == 7));
            chk("idle_cm_ram", 8'({cm_a, cm_b}), 8'h0);
            chk("idle_dbus",   8'({dbus_a, dbus_b}), 8'h0);
            chk("idle_rsp",    8'({rv_a, rv_b}), 8'h0);
            dbus_in = char_t'($urandom);
            tick();
        end
    endtask

    task automatic wait_ready(input int want_ph);
        int guard;
        guard = 0;
        while (!(m_ready === 1'b1 && (want_ph < 0 || ph == want_ph)) && guard < 64) begin
            cmd_valid = 1'b0;
            dbus_in = char_t'($urandom);
            tick();
            guard++;
        end
        chk("cmd_ready_wait", 8'(m_ready), 8'h1);
    endtask

    function automatic bit model_skip(input logic [7:0] addr);
        return (sel ? SKIP_B : SKIP_A) && lv[sel] && (la[sel] == addr);
    endfunction

    // Issue one command and check every bus cycle up to the response
    task automatic run_cmd(input logic [3:0] op, input logic [7:0] addr, input char_t wd,
                           input char_t rdv, input int want_ph, input bit hold);
        int    p_acc;
        int    lead;
        int    ncyc;
        bit    skip;
        char_t ed [16];
        bit    ec [16];
        wait_ready(want_ph);
        cmd_valid = 1'b1;
        cmd_op    = ioram_opa_t'(op);
        cmd_addr  = addr;
        cmd_wdata = wd;
        dbus_in   = char_t'($urandom);
        p_acc = ph;
        skip  = model_skip(addr);
        lead  = (p_acc == 7) ? 9 : 8 - p_acc;
        ncyc  = skip ? 8 : 16;
        for (int k = 0; k < 16; k++) begin
            ed[k] = 4'h0;
            ec[k] = 1'b0;
            if (!skip && k < 8) begin
                case (k % 8)
                    3: ed[k] = 4'h2;
                    4: ed[k] = 4'h1;
                    6: begin ed[k] = addr[3:0]; ec[k] = 1'b1; end
                    7: ed[k] = addr[7:4];
                    default: ;
                endcase
            end else begin
                case (k % 8)
                    3: ed[k] = 4'hE;
                    4: begin ed[k] = op; ec[k] = 1'b1; end
                    6: ed[k] = op[3] ? 4'h0 : wd;
                    default: ;
                endcase
            end
        end
        tick();
        cmd_valid = hold;
        for (int i = 1; i < lead; i++) begin
            chk("pre_dbus",  8'(m_dbus),  8'h0);
            chk("pre_cm",    8'(m_cm),    8'h0);
            chk("pre_rsp",   8'(m_rv),    8'h0);
            chk("pre_ready", 8'(m_ready), 8'h0);
            dbus_in = char_t'($urandom);
            tick();
        end
        for (int k = 0; k < ncyc; k++) begin
            chk("bus_dbus",   8'(m_dbus),  8'(ed[k]));
            chk("bus_cm_ram", 8'(m_cm),    8'(ec[k]));
            chk("rsp_valid",  8'(m_rv),    8'(k == ncyc - 1));
            chk("busy_ready", 8'(m_ready), 8'h0);
            if (k == ncyc - 1) chk("rsp_data", 8'(m_rd), 8'(op[3] ? rdv : 4'h0));
            if (k == ncyc - 2) dbus_in = rdv;
            else               dbus_in = char_t'($urandom);
            tick();
        end
        chk("ready_after", 8'(m_ready), 8'h1);
        chk("rsp_drop",    8'(m_rv),    8'h0);
        la[sel] = addr;
        lv[sel] = 1'b1;
    endtask

    // Start an RDM and pull reset in X1 of its I/O cycle
    task automatic reset_mid(input logic [7:0] addr);
        int  lead;
        bit  skip;
        wait_ready(1);
        cmd_valid = 1'b1;
        cmd_op    = RDM;
        cmd_addr  = addr;
        cmd_wdata = 4'h0;
        skip = model_skip(addr);
        lead = 8 - ph;
        tick();
        cmd_valid = 1'b0;
        repeat (lead - 1 + (skip ? 0 : 8) + 5) begin
            chk("mid_rsp", 8'(m_rv), 8'h0);
            dbus_in = char_t'($urandom);
            tick();
        end
        chk("mid_x1_cm",   8'(m_cm),   8'h0);
        chk("mid_x1_dbus", 8'(m_dbus), 8'h0);
        do_reset(2);
        idle_cycles(10);
    endtask

    initial begin
        logic [7:0] a;
        int         wp;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = WRM;
        cmd_addr = 8'h00;
        cmd_wdata = 4'h0;
        dbus_in = 4'h0;
        sel = 1'b0;
        ph = 7;
        la[0] = 8'h00;
        la[1] = 8'h00;

        do_reset(3);
        idle_cycles(24);

        sel = 1'b0;
        run_cmd(WRM, 8'h5A, 4'h9, 4'h0, 2, 1'b0);
        run_cmd(RDM, 8'h5A, 4'h0, 4'h9, -1, 1'b0);

        sel = 1'b1;
        run_cmd(WRM, 8'h5A, 4'h9, 4'h0, 2, 1'b0);
        run_cmd(RDM, 8'h5A, 4'h0, 4'h9, -1, 1'b0);

        sel = 1'b0;
        run_cmd(RDM, 8'h5A, 4'h0, 4'h3, 2, 1'b1);
        run_cmd(WR2, 8'h03, 4'hC, 4'h0, -1, 1'b0);
        run_cmd(RD0, 8'h03, 4'h0, 4'h7, 7, 1'b0);
        run_cmd(RDR, 8'h03, 4'h0, 4'hB, 4, 1'b0);

        reset_mid(8'h03);
        run_cmd(RDM, 8'h03, 4'h0, 4'h6, 2, 1'b0);

        for (int i = 0; i < 16; i++) begin
            sel = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       a = 8'h5A;
                1:       a = la[sel];
                default: a = 8'($urandom);
            endcase
            wp = int'($urandom_range(0, 8)) - 1;
            run_cmd(4'($urandom), a, char_t'($urandom), char_t'($urandom), wp, 1'b0);
        end

        sel = 1'b0;
        idle_cycles(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
